c2h_stream_arbiter: RTL
=======================

# c2h_stream_arbiter

Packet-granular round-robin arbiter that shares the single xDMA C2H AXI-stream (`s_axis_c2h_*`) among up to four readout sources, e.g. TI event blocks and ADC data. It sits between the source FIFOs and the xDMA C2H port, in the `CLKReg` domain. Each packet is delivered whole, and packets longer than `MAX_BEATS` are truncated. Per-source packet and truncation counters are exposed for the AXI-lite register bank.

## Interface
- `NUM_SRC`, 2: number of sources, legal range 1..4.
- `DATA_W`, 64: stream data width; keep width is `DATA_W/8`.
- `MAX_BEATS`, 256: maximum beats per delivered packet, legal range 2..65535.
- `CLKReg` in 1: single clock for all logic.
- `axi_aresetn` in 1: synchronous, active-low reset.
- `src_enable` in NUM_SRC: per-source enable from the register bank; sampled only during arbitration.
- `src_tdata` in NUM_SRC*DATA_W: source data, flattened; source i occupies bits [i*DATA_W +: DATA_W].
- `src_tkeep` in NUM_SRC*DATA_W/8: source byte keeps, flattened the same way.
- `src_tlast` in NUM_SRC: source end-of-packet.
- `src_tvalid` in NUM_SRC: source valid.
- `src_tready` out NUM_SRC: source ready.
- `s_axis_c2h_tdata` out DATA_W: data to xDMA.
- `s_axis_c2h_tkeep` out DATA_W/8: byte keeps to xDMA.
- `s_axis_c2h_tlast` out 1: end-of-packet to xDMA.
- `s_axis_c2h_tvalid` out 1: valid to xDMA.
- `s_axis_c2h_tready` in 1: ready from xDMA.
- `grant` out NUM_SRC: one-hot current owner; zero while IDLE.
- `pkt_cnt` out NUM_SRC*32: packets delivered per source. Wraps modulo 2^32.
- `trunc_cnt` out NUM_SRC*16: packets truncated per source. Saturates at 0xFFFF.

## Operation
- FSM states: IDLE, XFER, DRAIN.
- Round-robin pointer `last` holds the index of the most recently granted source. Reset value is NUM_SRC-1, so source 0 has first priority after reset.
- IDLE:
  - Request vector is `src_tvalid & src_enable`.
  - Winner is the first requesting index after `last`, searching cyclically.
  - On a winner: register the one-hot `grant`, update `last`, clear the beat counter, go to XFER.
  - With no request: stay in IDLE.
- XFER (combinational pass-through from the granted source g):
  - `s_axis_c2h_tdata/tkeep/tvalid` come from source g.
  - `src_tready[g]` = `s_axis_c2h_tready`; all other `src_tready` are 0.
  - `s_axis_c2h_tlast` = `src_tlast[g]` OR (beat counter == MAX_BEATS-1).
  - The beat counter (16 bits) increments on each handshake (tvalid & tready).
- XFER transitions, evaluated on a handshake:
  - Handshake with `src_tlast[g]`=1: increment `pkt_cnt[g]`, go to IDLE. This applies even if the beat is also beat MAX_BEATS-1; that case is a normal packet, not a truncation.
  - Handshake on beat MAX_BEATS-1 with `src_tlast[g]`=0: forced tlast is emitted; increment `pkt_cnt[g]` and `trunc_cnt[g]`, go to DRAIN.
- DRAIN:
  - `s_axis_c2h_tvalid`=0; `src_tready[g]`=1.
  - Remaining beats of source g are discarded.
  - On a handshake with `src_tlast[g]`=1, go to IDLE.
- `src_enable` deasserted mid-packet has no effect: the packet completes (XFER or DRAIN) before the source is skipped. A disabled source with tvalid=1 is never granted and its `src_tready` stays 0.
- Source tvalid dropping mid-packet in XFER: the arbiter holds the grant indefinitely and inserts no timeout.
- Counter updates are registered and visible the cycle after the qualifying handshake.

## Timing
- Reset (`axi_aresetn`=0 at a `CLKReg` edge): state=IDLE, `grant`=0, `last`=NUM_SRC-1, beat counter=0, all counters=0. All `src_tready`=0; `s_axis_c2h_tvalid`, `tdata`, `tkeep` and `tlast` are all 0. A packet cut off by reset is not completed; the downstream xDMA is reset by the same signal.
- Arbitration latency: source tvalid is sampled in IDLE cycle N, `grant` is valid in cycle N+1, and the first beat can hand off in N+1.
- Back-to-back packets: the tlast handshake occurs in cycle M, cycle M+1 is IDLE (one-cycle bubble), and the next packet starts at M+2.
- Datapath adds zero registers: output valid and data follow the granted source combinationally, and `src_tready` follows `s_axis_c2h_tready` combinationally.
- While `s_axis_c2h_tready`=0, the outputs mirror the held source values; AXI-stream stability is inherited from the source.
- Sustained throughput of one beat per cycle within a packet.

## Test plan
- Reset, then source 0 sends 4 beats with tlast on beat 4 → 4 beats out; tlast only on beat 4; `pkt_cnt[0]`=1; `grant`=0 at the cycle after the last beat.
- Sources 0 and 1 valid simultaneously from reset, each sending two 3-beat packets → order 0,1,0,1; exactly one idle cycle between packets.
- MAX_BEATS=8, source 1 sends 12 beats → 8 beats out with tlast on beat 8; 4 beats discarded with `s_axis_c2h_tvalid`=0; `trunc_cnt[1]`=1; `pkt_cnt[1]`=1.
- MAX_BEATS=8, source 0 sends exactly 8 beats with tlast on beat 8 → delivered whole; `trunc_cnt[0]`=0.
- `s_axis_c2h_tready` toggled randomly at 50% during a 16-beat packet → all 16 beats out in order with none duplicated; `src_tready[g]` matches `s_axis_c2h_tready` every cycle.
- `src_enable[0]` dropped mid-packet, with source 1 also pending → source 0's packet completes, source 1 is served next, and source 0 is not granted again. Then `axi_aresetn` is pulsed low for 1 cycle mid-packet → all outputs and counters read 0 on the next cycle.

Source files
------------

// File: rtl/c2h_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one xDMA C2H AXI-stream among up to four sources.
// Latency: one IDLE arbitration cycle per packet, then zero-register pass-through (one beat per cycle).
// Backpressure: s_axis_c2h_tready is forwarded combinationally to the granted source only; oversize packets are cut and drained.
module c2h_stream_arbiter #(
    parameter int NUM_SRC   = 2,
    parameter int DATA_W    = 64,
    parameter int MAX_BEATS = 256
) (
    input  logic                        CLKReg,
    input  logic                        axi_aresetn,
    input  logic [NUM_SRC-1:0]          src_enable,
    input  logic [NUM_SRC*DATA_W-1:0]   src_tdata,
    input  logic [NUM_SRC*DATA_W/8-1:0] src_tkeep,
    input  logic [NUM_SRC-1:0]          src_tlast,
    input  logic [NUM_SRC-1:0]          src_tvalid,
    output logic [NUM_SRC-1:0]          src_tready,
    output logic [DATA_W-1:0]           s_axis_c2h_tdata,
    output logic [DATA_W/8-1:0]         s_axis_c2h_tkeep,
    output logic                        s_axis_c2h_tlast,
    output logic                        s_axis_c2h_tvalid,
    input  logic                        s_axis_c2h_tready,
    output logic [NUM_SRC-1:0]          grant,
    output logic [NUM_SRC*32-1:0]       pkt_cnt,
    output logic [NUM_SRC*16-1:0]       trunc_cnt
);

    localparam int          KEEP_W    = DATA_W / 8;
    localparam int          IDX_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [15:0] LAST_BEAT = 16'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    // last_q doubles as the index of the current owner while XFER/DRAIN.
    logic [IDX_W-1:0]   last_q, last_d;
    logic [15:0]        beat_q, beat_d;
    logic [31:0]        pkt_cnt_q   [NUM_SRC];
    logic [31:0]        pkt_cnt_d   [NUM_SRC];
    logic [15:0]        trunc_cnt_q [NUM_SRC];
    logic [15:0]        trunc_cnt_d [NUM_SRC];

    logic [NUM_SRC-1:0] req;
    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;

    logic [DATA_W-1:0]  g_tdata;
    logic [KEEP_W-1:0]  g_tkeep;
    logic               g_tvalid;
    logic               g_tlast;
    logic               at_max;

    assign g_tdata  = src_tdata[int'(last_q)*DATA_W +: DATA_W];
    assign g_tkeep  = src_tkeep[int'(last_q)*KEEP_W +: KEEP_W];
    assign g_tvalid = src_tvalid[last_q];
    assign g_tlast  = src_tlast[last_q];
    assign at_max   = (beat_q == LAST_BEAT);
    assign grant    = grant_q;

    // Cyclic search for the first enabled requester after last_q; descending k so the nearest one wins.
    always_comb begin
        req     = src_tvalid & src_enable;
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            if (req[(int'(last_q) + k) % NUM_SRC]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'((int'(last_q) + k) % NUM_SRC);
            end
        end
    end

    // Next-state, counter updates and the combinational stream pass-through.
    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        last_d            = last_q;
        beat_d            = beat_q;
        pkt_cnt_d         = pkt_cnt_q;
        trunc_cnt_d       = trunc_cnt_q;
        src_tready        = '0;
        s_axis_c2h_tdata  = '0;
        s_axis_c2h_tkeep  = '0;
        s_axis_c2h_tlast  = 1'b0;
        s_axis_c2h_tvalid = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d          = XFER;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    last_d           = win_idx;
                    beat_d           = '0;
                end
            end

            XFER: begin
                s_axis_c2h_tdata   = g_tdata;
                s_axis_c2h_tkeep   = g_tkeep;
                s_axis_c2h_tvalid  = g_tvalid;
                s_axis_c2h_tlast   = g_tlast | at_max;
                src_tready[last_q] = s_axis_c2h_tready;
                if (g_tvalid && s_axis_c2h_tready) begin
                    beat_d = beat_q + 16'd1;
                    if (g_tlast) begin
                        // A genuine tlast on the final allowed beat is a normal packet.
                        pkt_cnt_d[last_q] = pkt_cnt_q[last_q] + 32'd1;
                        state_d           = IDLE;
                        grant_d           = '0;
                    end else if (at_max) begin
                        pkt_cnt_d[last_q] = pkt_cnt_q[last_q] + 32'd1;
                        if (trunc_cnt_q[last_q] != 16'hFFFF) begin
                            trunc_cnt_d[last_q] = trunc_cnt_q[last_q] + 16'd1;
                        end
                        state_d = DRAIN;
                    end
                end
            end

            DRAIN: begin
                // Swallow the tail of the oversize packet; nothing reaches the xDMA.
                src_tready[last_q] = 1'b1;
                if (g_tvalid && g_tlast) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge CLKReg) begin
        if (!axi_aresetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_SRC - 1);
            beat_q  <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                pkt_cnt_q[i]   <= '0;
                trunc_cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            for (int i = 0; i < NUM_SRC; i++) begin
                pkt_cnt_q[i]   <= pkt_cnt_d[i];
                trunc_cnt_q[i] <= trunc_cnt_d[i];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cnt_out
        assign pkt_cnt[gi*32 +: 32]   = pkt_cnt_q[gi];
        assign trunc_cnt[gi*16 +: 16] = trunc_cnt_q[gi];
    end

endmodule
